// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// opcode/funct values, FSM state encodings and datapath select encodings.
package mc_defs;

  localparam int unsigned STW_DEF = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [STW_DEF-1:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_AWB   = 4'd3,
    S_MA    = 4'd4,
    S_MR    = 4'd5,
    S_MWB   = 4'd6,
    S_MW    = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_OR = 2'b10} aluop_e;
  typedef enum logic [1:0] {SEL_PLAIN = 2'b00, SEL_ADDI = 2'b01, SEL_SLT = 2'b10} alusel_e;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_HI = 2'b10} extop_e;
  typedef enum logic [1:0] {NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_JMP = 2'b10, NPC_RS = 2'b11} npcop_e;
  typedef enum logic [1:0] {GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_31 = 2'b10, GPR_30 = 2'b11} gprsel_e;
  typedef enum logic [1:0] {WD_ALU = 2'b00, WD_DR = 2'b01, WD_PC4 = 2'b10} wdsel_e;

  // One-hot instruction class produced by mc_decode.
  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic addi;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bgez;
    logic j;
    logic jal;
  } insn_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder: one-hot instruction class plus an
// illegal flag for anything outside the supported subset.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output insn_t      ins,
  output logic       ill
);

  always_comb begin
    ins = '0;
    ill = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: ins.addu = 1'b1;
          FN_SUBU: ins.subu = 1'b1;
          FN_SLT:  ins.slt  = 1'b1;
          FN_JR:   ins.jr   = 1'b1;
          default: ill      = 1'b1;
        endcase
      end
      OP_ORI:  ins.ori  = 1'b1;
      OP_ADDI: ins.addi = 1'b1;
      OP_LUI:  ins.lui  = 1'b1;
      OP_LW:   ins.lw   = 1'b1;
      OP_SW:   ins.sw   = 1'b1;
      OP_BEQ:  ins.beq  = 1'b1;
      OP_BGEZ: ins.bgez = 1'b1;
      OP_J:    ins.j    = 1'b1;
      OP_JAL:  ins.jal  = 1'b1;
      default: ill      = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: sequences fetch/decode/execute/
// memory/writeback and drives datapath enables and mux selects.
module mc_ctrl
  import mc_defs::*;
#(
  parameter int unsigned STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     op,
  input  logic [5:0]     funct,
  input  logic           zero,
  input  logic           flow,
  input  logic           pos,
  output logic           PCWr,
  output logic           IRWr,
  output logic           RFWr,
  output logic           DMWr,
  output logic [1:0]     ALUOp,
  output logic [1:0]     ALUsel,
  output logic [1:0]     ExtOp,
  output logic           BSel,
  output logic [1:0]     NPCOp,
  output logic [1:0]     GPRSel,
  output logic [1:0]     WDSel,
  output logic           ill,
  output logic [STW-1:0] state
);

  state_e st_q;
  logic   flow_q;
  insn_t  ins;
  logic   ins_ill;
  logic   r_alu;
  logic   i_alu;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .ins   (ins),
    .ill   (ins_ill)
  );

  assign r_alu = ins.addu | ins.subu | ins.slt;
  assign i_alu = ins.ori | ins.addi | ins.lui;
  assign state = STW'(st_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_FETCH;
      flow_q <= 1'b0;
    end else begin
      case (st_q)
        S_FETCH: st_q <= S_DCD;
        S_DCD: begin
          if (r_alu | i_alu)                  st_q <= S_EXE;
          else if (ins.lw | ins.sw)           st_q <= S_MA;
          else if (ins.beq | ins.bgez)        st_q <= S_BR;
          else if (ins.j | ins.jal | ins.jr)  st_q <= S_JMP;
          else                                st_q <= S_FETCH;
        end
        S_EXE: begin
          st_q   <= S_AWB;
          flow_q <= (op == OP_ADDI) ? flow : 1'b0;
        end
        S_AWB:   st_q <= S_FETCH;
        S_MA:    st_q <= ins.lw ? S_MR : S_MW;
        S_MR:    st_q <= S_MWB;
        S_MWB:   st_q <= S_FETCH;
        S_MW:    st_q <= S_FETCH;
        S_BR:    st_q <= S_FETCH;
        S_JMP:   st_q <= S_FETCH;
        default: st_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from the state register; reset masks every output so a
  // held reset never produces a write regardless of the current state.
  always_comb begin
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    RFWr   = 1'b0;
    DMWr   = 1'b0;
    ALUOp  = '0;
    ALUsel = '0;
    ExtOp  = '0;
    BSel   = 1'b0;
    NPCOp  = '0;
    GPRSel = '0;
    WDSel  = '0;
    ill    = 1'b0;
    if (!rst) begin
      case (st_q)
        S_FETCH: begin
          IRWr  = 1'b1;
          PCWr  = 1'b1;
          NPCOp = NPC_PC4;
        end
        S_DCD: ill = ins_ill;
        S_EXE: begin
          if (ins.subu)           ALUOp  = ALU_SUB;
          if (ins.ori | ins.lui)  ALUOp  = ALU_OR;
          if (ins.slt)            ALUsel = SEL_SLT;
          if (ins.addi)           ALUsel = SEL_ADDI;
          if (ins.lui)            ExtOp  = EXT_HI;
          if (ins.addi)           ExtOp  = EXT_SIGN;
          BSel = i_alu;
        end
        S_AWB: begin
          RFWr  = 1'b1;
          WDSel = WD_ALU;
          if (r_alu)                     GPRSel = GPR_RD;
          else if (ins.addi && flow_q)   GPRSel = GPR_30;
          else                           GPRSel = GPR_RT;
        end
        S_MA: begin
          ALUOp  = ALU_ADD;
          ALUsel = SEL_PLAIN;
          ExtOp  = EXT_SIGN;
          BSel   = 1'b1;
        end
        S_MWB: begin
          RFWr   = 1'b1;
          GPRSel = GPR_RT;
          WDSel  = WD_DR;
        end
        S_MW: DMWr = 1'b1;
        S_BR: begin
          ALUOp = ALU_SUB;
          NPCOp = NPC_BR;
          PCWr  = (ins.beq & zero) | (ins.bgez & pos);
        end
        S_JMP: begin
          PCWr = 1'b1;
          if (ins.jr) NPCOp = NPC_RS;
          else        NPCOp = NPC_JMP;
          if (ins.jal) begin
            RFWr   = 1'b1;
            GPRSel = GPR_31;
            WDSel  = WD_PC4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
